vga_line_fetch: RTL and testbench

//   Pixel-fetch stage fed by the VGA timing generator. On each line_start it fetches
//   one scanline of 8-bit pixels from framebuffer memory into a ping-pong line buffer.
//   It then drives rgb for the line currently on screen.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_line_ram.sv | 53 +++++
 rtl/vga_line_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_vga_line_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and pixel helpers for the VGA line-fetch stage.
package vga_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned MEM_DATA_W  = 16;
    localparam int unsigned H_WORDS_DEF = 320;

    // Fetch FSM: idle between lines, or issuing read requests for one scanline.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StReq  = 1'b1
    } fetch_state_e;

    // Each memory word packs two pixels; the even column lives in the upper byte.
    function automatic logic [PIX_W-1:0] pix_select(input logic [MEM_DATA_W-1:0] data,
                                                    input logic                  odd);
        return odd ? data[PIX_W-1:0] : data[MEM_DATA_W-1:PIX_W];
    endfunction

endpackage

// File: rtl/vga_line_ram.sv
// Ping-pong line buffer: two banks of H_WORDS 16-bit words, one write port and one
// registered read port. No reset; contents are undefined until written.
module vga_line_ram
    import vga_pkg::*;
#(
    parameter int unsigned H_WORDS = H_WORDS_DEF,
    parameter int unsigned WORD_W  = $clog2(H_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic                  i_wr_bank,
    input  logic [WORD_W-1:0]     i_wr_word,
    input  logic [MEM_DATA_W-1:0] i_wr_data,
    input  logic                  i_rd_bank,
    input  logic [WORD_W-1:0]     i_rd_word,
    output logic [MEM_DATA_W-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 2 * H_WORDS;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [MEM_DATA_W-1:0] r_mem [DEPTH];
    logic [MEM_DATA_W-1:0] r_rd_data;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    // Word indices past the end of a line (x beyond 640 px) never touch the array.
    assign w_wr_ok = (32'(i_wr_word) < H_WORDS);
    assign w_rd_ok = (32'(i_rd_word) < H_WORDS);

    // Bank 1 sits directly above bank 0 so the array is exactly 2*H_WORDS deep.
    assign w_wr_idx = !w_wr_ok  ? '0 :
                      i_wr_bank ? IDX_W'(H_WORDS) + IDX_W'(i_wr_word) : IDX_W'(i_wr_word);
    assign w_rd_idx = !w_rd_ok  ? '0 :
                      i_rd_bank ? IDX_W'(H_WORDS) + IDX_W'(i_rd_word) : IDX_W'(i_rd_word);

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && w_wr_ok) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
    end

    // Registered read port; out-of-line reads return black.
    always_ff @(posedge i_clk) begin
        r_rd_data <= w_rd_ok ? r_mem[w_rd_idx] : '0;
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vga_line_fetch.sv
// VGA pixel-fetch stage: prefetches the next scanline into a ping-pong buffer while the
// current line is displayed, and delays the syncs to match the 2-clk pixel pipeline.
module vga_line_fetch
    import vga_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] FB_BASE     = '0,
    parameter int unsigned       LINE_STRIDE = 320,
    parameter int unsigned       H_WORDS     = H_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_start,
    input  logic                  vlookahead,
    input  logic [9:0]            y,
    input  logic [9:0]            x,
    input  logic                  bright,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    output logic [PIX_W-1:0]      rgb,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  underrun
);

    localparam int unsigned       WORD_W    = $clog2(H_WORDS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(H_WORDS - 1);

    // Fetch side
    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_word_next;
    logic                r_bank;
    logic                w_bank_next;
    logic                r_mem_req;
    logic                w_mem_req_next;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic                r_underrun;
    logic                w_underrun_next;
    logic                w_wr_en;
    logic                w_start;
    logic                w_last;
    logic [31:0]         w_line_prod;
    logic [ADDR_W-1:0]   w_line_addr;

    // Display side
    logic [MEM_DATA_W-1:0] w_rd_data;
    logic                  r_bright_d1;
    logic                  r_odd_d1;
    logic [PIX_W-1:0]      r_rgb;
    logic [1:0]            r_hsync_sr;
    logic [1:0]            r_vsync_sr;

    assign w_start = line_start && vlookahead;
    assign w_last  = (r_word == LAST_WORD);

    // Line base address; the product is truncated so large y wraps silently.
    assign w_line_prod = 32'(y) * LINE_STRIDE;
    assign w_line_addr = FB_BASE + w_line_prod[ADDR_W-1:0];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; a new line_start always wins over a pending ack.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = StReq;
                end
            end
            StReq: begin
                if (line_start) begin
                    w_state_next = vlookahead ? StReq : StIdle;
                end else if (mem_ack && w_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs: request/address generation, buffer write strobe and underrun flag.
    always_comb begin
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_word_next     = r_word;
        w_bank_next     = r_bank;
        w_underrun_next = r_underrun;
        w_wr_en         = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_mem_req_next  = 1'b1;
                    w_mem_addr_next = w_line_addr;
                    w_word_next     = '0;
                    w_bank_next     = y[0];
                end
            end
            StReq: begin
                if (line_start) begin
                    // Previous line never finished; its stale words are shown as-is.
                    w_underrun_next = 1'b1;
                    if (vlookahead) begin
                        w_mem_req_next  = 1'b1;
                        w_mem_addr_next = w_line_addr;
                        w_word_next     = '0;
                        w_bank_next     = y[0];
                    end else begin
                        w_mem_req_next = 1'b0;
                    end
                end else if (mem_ack) begin
                    w_wr_en         = 1'b1;
                    w_word_next     = r_word + 1'b1;
                    w_mem_addr_next = r_mem_addr + 1'b1;
                    if (w_last) begin
                        w_mem_req_next = 1'b0;
                    end
                end
            end
            default: w_mem_req_next = 1'b0;
        endcase
    end

    // Fetch datapath registers; mem_req drops as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_word     <= '0;
            r_bank     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_word     <= w_word_next;
            r_bank     <= w_bank_next;
            r_underrun <= w_underrun_next;
        end
    end

    // Display reads the bank opposite to the one y (one line ahead) is filling.
    vga_line_ram #(
        .H_WORDS (H_WORDS),
        .WORD_W  (WORD_W)
    ) u_line_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (r_bank),
        .i_wr_word (r_word),
        .i_wr_data (mem_rdata),
        .i_rd_bank (~y[0]),
        .i_rd_word (WORD_W'(x[9:1])),
        .o_rd_data (w_rd_data)
    );

    // Pixel pipeline: stage 1 tracks the RAM read, stage 2 selects the byte and blanks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bright_d1 <= 1'b0;
            r_odd_d1    <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_bright_d1 <= bright;
            r_odd_d1    <= x[0];
            r_rgb       <= r_bright_d1 ? pix_select(w_rd_data, r_odd_d1) : '0;
        end
    end

    // Sync delay line, two stages to stay aligned with rgb; idles high (inactive).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync_sr <= 2'b11;
            r_vsync_sr <= 2'b11;
        end else begin
            r_hsync_sr <= {r_hsync_sr[0], hsync_in};
            r_vsync_sr <= {r_vsync_sr[0], vsync_in};
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign underrun  = r_underrun;
    assign rgb       = r_rgb;
    assign hsync_out = r_hsync_sr[1];
    assign vsync_out = r_vsync_sr[1];

endmodule

// File: tb/tb_vga_line_fetch.sv
// Self-checking bench for vga_line_fetch: address and pixel scoreboards plus direct checks.
module tb_vga_line_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic        vlookahead = 1'b0;
    logic [9:0]  y = '0;
    logic [9:0]  x = '0;
    logic        bright = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [7:0]  rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_line_fetch u_dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .vlookahead (vlookahead),
        .y          (y),
        .x          (x),
        .bright     (bright),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .underrun   (underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] data_fn(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h3C5A;
    endfunction

    function automatic logic [7:0] pick(input logic [15:0] w, input logic odd);
        return odd ? w[7:0] : w[15:8];
    endfunction

    // Memory model and address scoreboard
    logic [15:0] exp_addr_q[$];
    logic [15:0] shadow [2][320];
    int          ack_period = 0;
    int          stall_cnt = 0;
    int          fill_bank = 0;
    int          ack_idx = 0;
    int          first_ack_cyc = 0;
    int          last_ack_cyc = 0;
    bit          hold_chk = 1'b0;
    bit          force_en = 1'b0;
    logic [15:0] force_addr = '0;
    logic [15:0] force_data = '0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;
    logic        rsp_ack;
    logic [15:0] rsp_data;
    logic [15:0] rsp_exp;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack   = 1'b0;
            stall_cnt = 0;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
        end else begin
            if (hold_chk && prev_req && !prev_ack) begin
                check_eq("req_hold", mem_req, 1);
                check_eq("addr_hold", mem_addr, prev_addr);
            end
            rsp_ack = 1'b0;
            if (mem_req && ack_period != 0) begin
                stall_cnt++;
                rsp_ack = (stall_cnt % ack_period) == 0;
            end
            if (rsp_ack) begin
                rsp_data = (force_en && mem_addr == force_addr) ? force_data : data_fn(mem_addr);
                if (exp_addr_q.size() == 0) begin
                    check_eq("unexpected_req", exp_addr_q.size(), 1);
                end else begin
                    rsp_exp = exp_addr_q.pop_front();
                    check_eq("mem_addr", mem_addr, rsp_exp);
                end
                if (ack_idx < 320) shadow[fill_bank][ack_idx] = rsp_data;
                ack_idx++;
                if (ack_idx == 1) first_ack_cyc = cyc;
                last_ack_cyc = cyc;
                mem_rdata = rsp_data;
            end
            mem_ack   = rsp_ack;
            prev_req  = mem_req;
            prev_ack  = rsp_ack;
            prev_addr = mem_addr;
        end
    end

    // Pixel/sync scoreboard: each entry is due 2 clk after the inputs were driven.
    typedef struct {
        int         due;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } pix_exp_t;
    pix_exp_t pix_q[$];
    pix_exp_t pe;

    always @(posedge clk) begin
        #1;
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pe = pix_q.pop_front();
            check_eq("rgb", rgb, pe.rgb);
            check_eq("hsync_out", hsync_out, pe.hs);
            check_eq("vsync_out", vsync_out, pe.vs);
        end
    end

    task automatic push_line(input int yv);
        int base;
        base = (yv * 320) % 65536;
        for (int i = 0; i < 320; i++) exp_addr_q.push_back(16'((base + i) % 65536));
    endtask

    task automatic start_fetch(input logic [9:0] yv, input logic vla);
        @(negedge clk);
        y          = yv;
        vlookahead = vla;
        line_start = 1'b1;
        if (vla) begin
            fill_bank = int'(yv[0]);
            ack_idx   = 0;
        end
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_fetch(input int budget);
        int n;
        n = 0;
        while (exp_addr_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("fetch_done", exp_addr_q.size(), 0);
        exp_addr_q.delete();
        @(negedge clk);
    endtask

    task automatic drive_px(input logic [9:0] xv, input logic br, input logic hs,
                            input logic vs, input logic [7:0] exp_rgb);
        @(negedge clk);
        x        = xv;
        bright   = br;
        hsync_in = hs;
        vsync_in = vs;
        pix_q.push_back('{due: cyc + 2, rgb: exp_rgb, hs: hs, vs: vs});
    endtask

    task automatic drain_px();
        int n;
        n = 0;
        while (pix_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("pix_drain", pix_q.size(), 0);
        pix_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_rgb", rgb, 0);
        check_eq("rst_hsync", hsync_out, 1);
        check_eq("rst_vsync", vsync_out, 1);
        check_eq("rst_underrun", underrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch y=5 with ack always high: 1600..1919 back to back
        ack_period = 1;
        push_line(5);
        start_fetch(10'd5, 1'b1);
        wait_fetch(2000);
        check_eq("t1_span", last_ack_cyc - first_ack_cyc, 319);
        check_eq("t1_req_drop", mem_req, 0);

        // Address wrap: y=1023 -> 65216..65535
        push_line(1023);
        start_fetch(10'd1023, 1'b1);
        wait_fetch(2000);
        check_eq("wrap_span", last_ack_cyc - first_ack_cyc, 319);
        check_eq("wrap_req_drop", mem_req, 0);

        // Fill bank 0 from y=2 with word 0 forced to A5C3, then display it with y=1
        force_en   = 1'b1;
        force_addr = 16'd640;
        force_data = 16'hA5C3;
        push_line(2);
        start_fetch(10'd2, 1'b1);
        wait_fetch(2000);
        force_en   = 1'b0;
        y          = 10'd1;
        vlookahead = 1'b0;
        drive_px(10'd0, 1'b1, 1'b1, 1'b1, 8'hA5);
        drive_px(10'd0, 1'b1, 1'b1, 1'b1, 8'hA5);
        drive_px(10'd1, 1'b1, 1'b1, 1'b1, 8'hC3);
        drive_px(10'd1, 1'b1, 1'b1, 1'b1, 8'hC3);
        drive_px(10'd1, 1'b0, 1'b1, 1'b1, 8'h00);
        drive_px(10'd638, 1'b1, 1'b1, 1'b1, pick(shadow[0][319], 1'b0));
        drive_px(10'd639, 1'b1, 1'b1, 1'b1, pick(shadow[0][319], 1'b1));
        drive_px(10'd639, 1'b0, 1'b1, 1'b1, 8'h00);
        drain_px();

        // Stalled ack every 3rd clk into bank 1, then sweep the whole line from bank 1
        ack_period = 3;
        hold_chk   = 1'b1;
        push_line(7);
        start_fetch(10'd7, 1'b1);
        wait_fetch(5000);
        hold_chk   = 1'b0;
        check_eq("t2_req_drop", mem_req, 0);
        check_eq("t2_ack_count", ack_idx, 320);
        y          = 10'd0;
        vlookahead = 1'b0;
        for (int i = 0; i < 640; i++) begin
            drive_px(10'(i), 1'b1, 1'b1, 1'b1, pick(shadow[1][i / 2], i[0]));
            drive_px(10'(i), 1'b1, 1'b1, 1'b1, pick(shadow[1][i / 2], i[0]));
        end
        drain_px();

        // Underrun: ack never comes
        ack_period = 0;
        start_fetch(10'd9, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("t4_req", mem_req, 1);
        check_eq("t4_addr", mem_addr, 2880);
        check_eq("t4_no_underrun", underrun, 0);
        start_fetch(10'd10, 1'b1);
        check_eq("t4_underrun", underrun, 1);
        check_eq("t4_restart_req", mem_req, 1);
        check_eq("t4_restart_addr", mem_addr, 3200);
        repeat (5) @(negedge clk);
        check_eq("t4_underrun_sticky", underrun, 1);
        start_fetch(10'd11, 1'b0);
        check_eq("t4_abort_req", mem_req, 0);
        check_eq("t4_underrun_held", underrun, 1);
        start_fetch(10'd12, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("t4_idle_no_fetch", mem_req, 0);

        // Sync alignment with bright low
        y = 10'd0;
        for (int i = 0; i < 12; i++) begin
            drive_px(10'd0, 1'b0, !(i >= 3 && i <= 5), !(i >= 5 && i <= 8), 8'h00);
        end
        drain_px();

        // Async reset in the middle of a request
        start_fetch(10'd3, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("t6_req_before", mem_req, 1);
        check_eq("t6_underrun_before", underrun, 1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_req_async", mem_req, 0);
        check_eq("t6_addr_async", mem_addr, 0);
        check_eq("t6_underrun_async", underrun, 0);
        check_eq("t6_rgb_async", rgb, 0);
        check_eq("t6_hsync_async", hsync_out, 1);
        check_eq("t6_vsync_async", vsync_out, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_idle_after", mem_req, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
